mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage (M). Sits between the execute stage and the writeback stage.
- Captures the execute-to-memory bus, which already holds the raw load word returned by data SRAM, in one pipeline register.
- Performs load byte/half extraction with sign or zero extension and selects the final register write data.
- Drives the M-to-D forwarding bus and the memory-to-writeback bus. Tracks exceptions so younger instructions are squashed until flush.

Parameters:
- EM_BUS_W, 294, width of incoming execute-to-memory bus (layout below).
- MW_BUS_W, 258, width of outgoing memory-to-writeback bus.
- MD_FOR_W, 116, width of forwarding bus to decode.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high. All state clears immediately on assertion.
- W_allowin  in  1  writeback stage can accept this cycle.
- M_allowin  out  1  this stage can accept from execute.
- EM_valid  in  1  execute presents a valid instruction.
- EM_BUS  in  EM_BUS_W  fields, MSB first: rdata[293:262], pb[261:195], pc[194:163], rf_wdata[162:131], gr_we[130], dest[129:125], res_from_mem[124:121], vaddr[120:89], ex[88], ecode[87:80], esubcode[79], csr_addr[78:65], csr_we[64], csr_wmask[63:32], csr_wdata[31:0].
- MW_valid  out  1  valid instruction offered to writeback.
- MW_BUS  out  MW_BUS_W  {pb 67, pc 32, final_wdata 32, gr_we 1, dest 5, badv 32, ex 1, ecode 8, esubcode 1, csr_addr 14, csr_we 1, csr_wmask 32, csr_wdata 32}.
- MD_for_BUS  out  MD_FOR_W  {dest masked 5, final_wdata 32, csr_we masked 1, csr_addr 14, csr_wmask 32, csr_wdata 32}.
- ex_M  out  1  held instruction carries an exception.
- ex_en  in  1  exception/ertn flush from writeback/CSR.

Behaviour:
- State: bus register EM_BUS_M (EM_BUS_W bits), M_valid, ex_flag. All are reset to 0 asynchronously.
- With the register cleared, every output is 0 during reset, except M_allowin = 1.
- Handshake: M_ready_go = 1 (load data already captured upstream). M_allowin = !M_valid || W_allowin. MW_valid = M_valid.
- Register update priority:
  1. rst.
  2. ex_en: M_valid <= 0 and EM_BUS_M <= 0.
  3. M_allowin: EM_BUS_M <= EM_BUS when EM_valid; M_valid <= EM_valid && !ex_flag && !ex_M.
  4. Otherwise hold.
- Latency: one cycle from accept to MW_valid. Full throughput when W_allowin is held high.
- ex_flag: set when ex_M=1, cleared on ex_en. Set has priority if both occur in the same cycle; the flush then clears M_valid, so ex_M drops the next cycle.
- ex_M = M_valid && ex field.
- Load extraction uses res_from_mem and vaddr[1:0]:
  - 1111 ld.w: rdata.
  - 0011 ld.h: sign-extend rdata[15:0] if vaddr[1]=0, else rdata[31:16].
  - 0111 ld.hu: same half selection, zero-extended.
  - 0001 ld.b: sign-extend byte vaddr[1:0].
  - 0101 ld.bu: same byte selection, zero-extended.
  - 0000: not a load; final_wdata = rf_wdata.
  - Any other code: final_wdata = 0.
- Exceptions:
  - gr_we on MW_BUS and the forwarding dest mask are forced to 0 when ex=1.
  - badv = vaddr, passed through unchanged.
  - pb fields pass through unchanged.
- Forwarding masks:
  - dest masked = dest & {5{M_valid && gr_we && !ex}}.
  - csr_we masked = csr_we && M_valid.
- Stall: W_allowin=0 with M_valid=1 holds EM_BUS_M and all outputs stable. Execute is not accepted.
- Reset mid-operation: in-flight instruction is discarded and ex_flag is cleared.

Decomposition:
- Shared include (Defines.vh) gets:
  - bus widths MW_BUS_Wid and MD_for_BUS_Wid;
  - res_from_mem encodings LD_W, LD_H, LD_HU, LD_B, LD_BU.
- One natural sub-module: load_align (combinational: rdata, vaddr[1:0], res_from_mem -> extracted word).

Test Plan:
- ld.b at vaddr 0x1003, rdata 0x80FF_1234, W_allowin=1 -> next cycle MW_valid=1, final_wdata 0xFFFF_FF80, MD dest = instruction dest.
- ld.hu at vaddr 0x2002, rdata 0x8001_7FFF -> final_wdata 0x0000_8001. ld.h at vaddr 0x2000 with same rdata -> 0x0000_7FFF.
- Non-load add, rf_wdata 0x1234_5678, W_allowin=0 for 3 cycles -> M_allowin=0, MW_BUS constant, released on cycle 4.
- Instruction with ex=1, ecode 0x09, gr_we=1 -> ex_M=1, MW gr_we=0, MD dest=0. Following EM_valid instructions are accepted with M_valid=0 until ex_en pulses; after that the next accept is valid.
- ex_en asserted while M_valid=1 and EM_valid=1 -> next cycle M_valid=0, MW_BUS=0.
- rst asserted mid-stall -> outputs go to 0 immediately (async), M_allowin=1, ex_flag=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_pkg
//  Brief    : Bus widths, load-type encodings and bus layouts for the M stage.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int c_em_bus_wid     = 294;
    localparam int c_mw_bus_wid     = 258;
    localparam int c_md_for_bus_wid = 116;

    localparam logic [3:0] c_ld_none = 4'b0000;
    localparam logic [3:0] c_ld_w    = 4'b1111;
    localparam logic [3:0] c_ld_h    = 4'b0011;
    localparam logic [3:0] c_ld_hu   = 4'b0111;
    localparam logic [3:0] c_ld_b    = 4'b0001;
    localparam logic [3:0] c_ld_bu   = 4'b0101;

    // Field order is MSB first and must match the execute stage packing.
    typedef struct packed {
        logic [31:0] rdata;
        logic [66:0] pb;
        logic [31:0] pc;
        logic [31:0] rf_wdata;
        logic        gr_we;
        logic [4:0]  dest;
        logic [3:0]  res_from_mem;
        logic [31:0] vaddr;
        logic        ex;
        logic [7:0]  ecode;
        logic        esubcode;
        logic [13:0] csr_addr;
        logic        csr_we;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wdata;
    } em_bus_t;

    typedef struct packed {
        logic [66:0] pb;
        logic [31:0] pc;
        logic [31:0] final_wdata;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] badv;
        logic        ex;
        logic [7:0]  ecode;
        logic        esubcode;
        logic [13:0] csr_addr;
        logic        csr_we;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wdata;
    } mw_bus_t;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] final_wdata;
        logic        csr_we;
        logic [13:0] csr_addr;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wdata;
    } md_for_bus_t;

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_if
//  Brief    : Execute->M input, M->W output and M->D forwarding signal bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_stage_if #(
    parameter int EM_BUS_W = mem_stage_pkg::c_em_bus_wid,
    parameter int MW_BUS_W = mem_stage_pkg::c_mw_bus_wid,
    parameter int MD_FOR_W = mem_stage_pkg::c_md_for_bus_wid
);
    logic                W_allowin;
    logic                M_allowin;
    logic                EM_valid;
    logic [EM_BUS_W-1:0] EM_BUS;
    logic                MW_valid;
    logic [MW_BUS_W-1:0] MW_BUS;
    logic [MD_FOR_W-1:0] MD_for_BUS;
    logic                ex_M;
    logic                ex_en;

    modport master (
        output W_allowin, EM_valid, EM_BUS, ex_en,
        input  M_allowin, MW_valid, MW_BUS, MD_for_BUS, ex_M
    );

    modport slave (
        input  W_allowin, EM_valid, EM_BUS, ex_en,
        output M_allowin, MW_valid, MW_BUS, MD_for_BUS, ex_M
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_load_align.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_load_align
//  Brief    : Byte/half extraction with sign or zero extension of a load word.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  wire logic [31:0] i_rdata,
    input  wire logic [1:0]  i_vaddr_lo,
    input  wire logic [3:0]  i_res_from_mem,
    output logic      [31:0] o_load_word
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    always_comb begin
        w_half = i_vaddr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_vaddr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    // Unknown encodings yield zero rather than a partial load.
    always_comb begin
        case (i_res_from_mem)
            c_ld_w:  o_load_word = i_rdata;
            c_ld_h:  o_load_word = {{16{w_half[15]}}, w_half};
            c_ld_hu: o_load_word = {16'h0000, w_half};
            c_ld_b:  o_load_word = {{24{w_byte[7]}}, w_byte};
            c_ld_bu: o_load_word = {24'h000000, w_byte};
            default: o_load_word = 32'h0000_0000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Brief    : Memory-access pipeline stage: load alignment, writeback/forward
//             bus generation and exception squash tracking.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  rst,
    mem_stage_if.slave bus
);

    em_bus_t     r_em_bus;
    logic        r_m_valid;
    logic        r_ex_flag;

    em_bus_t     w_em_in;
    logic        w_m_allowin;
    logic        w_ex_m;
    logic [31:0] w_load_word;
    logic [31:0] w_final_wdata;
    mw_bus_t     w_mw_bus;
    md_for_bus_t w_md_bus;

    assign w_em_in     = em_bus_t'(bus.EM_BUS);
    assign w_m_allowin = !r_m_valid || bus.W_allowin;
    assign w_ex_m      = r_m_valid && r_em_bus.ex;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_em_bus  <= '0;
            r_m_valid <= 1'b0;
        end else if (bus.ex_en) begin
            r_em_bus  <= '0;
            r_m_valid <= 1'b0;
        end else if (w_m_allowin) begin
            if (bus.EM_valid) begin
                r_em_bus <= w_em_in;
            end
            // Anything younger than a held or pending exception enters squashed.
            r_m_valid <= bus.EM_valid && !r_ex_flag && !w_ex_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_flag <= 1'b0;
        end else if (w_ex_m) begin
            r_ex_flag <= 1'b1;
        end else if (bus.ex_en) begin
            r_ex_flag <= 1'b0;
        end
    end

    mem_stage_load_align u_load_align (
        .i_rdata        (r_em_bus.rdata),
        .i_vaddr_lo     (r_em_bus.vaddr[1:0]),
        .i_res_from_mem (r_em_bus.res_from_mem),
        .o_load_word    (w_load_word)
    );

    assign w_final_wdata = (r_em_bus.res_from_mem == c_ld_none) ? r_em_bus.rf_wdata
                                                                : w_load_word;

    always_comb begin
        w_mw_bus             = '0;
        w_mw_bus.pb          = r_em_bus.pb;
        w_mw_bus.pc          = r_em_bus.pc;
        w_mw_bus.final_wdata = w_final_wdata;
        w_mw_bus.gr_we       = r_em_bus.gr_we && !r_em_bus.ex;
        w_mw_bus.dest        = r_em_bus.dest;
        w_mw_bus.badv        = r_em_bus.vaddr;
        w_mw_bus.ex          = r_em_bus.ex;
        w_mw_bus.ecode       = r_em_bus.ecode;
        w_mw_bus.esubcode    = r_em_bus.esubcode;
        w_mw_bus.csr_addr    = r_em_bus.csr_addr;
        w_mw_bus.csr_we      = r_em_bus.csr_we;
        w_mw_bus.csr_wmask   = r_em_bus.csr_wmask;
        w_mw_bus.csr_wdata   = r_em_bus.csr_wdata;
    end

    // Decode only sees a destination that will really be written.
    always_comb begin
        w_md_bus             = '0;
        w_md_bus.dest        = r_em_bus.dest &
                               {5{r_m_valid && r_em_bus.gr_we && !r_em_bus.ex}};
        w_md_bus.final_wdata = w_final_wdata;
        w_md_bus.csr_we      = r_em_bus.csr_we && r_m_valid;
        w_md_bus.csr_addr    = r_em_bus.csr_addr;
        w_md_bus.csr_wmask   = r_em_bus.csr_wmask;
        w_md_bus.csr_wdata   = r_em_bus.csr_wdata;
    end

    assign bus.M_allowin  = w_m_allowin;
    assign bus.MW_valid   = r_m_valid;
    assign bus.MW_BUS     = w_mw_bus;
    assign bus.MD_for_BUS = w_md_bus;
    assign bus.ex_M       = w_ex_m;

endmodule
`default_nettype wire
